control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ir_op, input, 2 bits: opcode field IR[7:6]; 00 ADD, 01 AND, 10 JMP, 11 INC.
REQ-004 SHALL have port clr_pc, output, 1 bit: clears the program counter.
REQ-005 SHALL have port ld_pc, output, 1 bit: loads the program counter from the IR address field.
REQ-006 SHALL have port inc_pc, output, 1 bit: increments the program counter.
REQ-007 SHALL have port ld_ar, output, 1 bit: loads the address register.
REQ-008 SHALL have port ar_sel, output, 1 bit: AR source; 0 = PC, 1 = IR[5:0].
REQ-009 SHALL have port mem_rd, output, 1 bit: memory read strobe.
REQ-010 SHALL have port ld_ir, output, 1 bit: loads the instruction register from memory.
REQ-011 SHALL have port ld_dr, output, 1 bit: loads the data register from memory.
REQ-012 SHALL have port ld_ac, output, 1 bit: loads the accumulator from the ALU.
REQ-013 SHALL have port clr_ac, output, 1 bit: clears the accumulator.
REQ-014 SHALL have port inc_ac, output, 1 bit: increments the accumulator.
REQ-015 SHALL have port alu_op, output, 2 bits: ALU operation, equal to ir_op in EXEC2, else 00.
REQ-016 SHALL have port state_out, output, 3 bits: current state encoding, for debug.

Function
REQ-017 SHALL implement a Moore FSM with one registered 3-bit state; states are RST=0, F1=1, F2=2, DEC=3, EX1=4, EX2=5.
REQ-018 SHALL decode all outputs combinationally from the state; only DEC and EX2 SHALL also use ir_op.
REQ-019 SHALL drive every output not listed below as 0 in every state.
REQ-020 RST SHALL assert clr_pc=1 and clr_ac=1, then go to F1.
REQ-021 F1 SHALL assert ld_ar=1 with ar_sel=0 (AR<=PC), then go to F2.
REQ-022 F2 SHALL assert mem_rd=1, ld_ir=1 and inc_pc=1, then go to DEC.
REQ-023 DEC with ir_op=00 or 01 SHALL assert ld_ar=1 with ar_sel=1, then go to EX1.
REQ-024 DEC with ir_op=10 SHALL assert ld_pc=1, then go to F1.
REQ-025 DEC with ir_op=11 SHALL assert inc_ac=1, then go to F1.
REQ-026 EX1 SHALL assert mem_rd=1 and ld_dr=1, then go to EX2.
REQ-027 EX2 SHALL assert ld_ac=1 and alu_op=ir_op, then go to F1.
REQ-028 Instruction latency SHALL be exactly 3 cycles (F1..DEC) for JMP/INC and 5 cycles (F1..EX2) for ADD/AND.
REQ-029 inc_pc SHALL pulse exactly once per instruction; ld_pc and inc_pc SHALL never be high together.
REQ-030 Unused state codes 6 and 7 SHALL transition to RST on the next edge with all outputs 0.

Reset
REQ-031 rst=1 at a rising edge SHALL force the state to RST regardless of current state or ir_op, including mid-instruction.
REQ-032 While rst is held high, the block SHALL remain in RST with clr_pc=1, clr_ac=1, and all other outputs 0.
REQ-033 The state before the first rst edge is undefined; the bench SHALL apply rst for at least 1 cycle.

Configuration
REQ-034 Macro CU_STEP_EN defined SHALL add input port step (1 bit) and state HOLD=6.
REQ-035 With CU_STEP_EN defined, every transition to F1 (from RST, DEC, EX2) SHALL instead go to HOLD.
REQ-036 With CU_STEP_EN defined, HOLD SHALL drive all outputs 0 and stay in HOLD until step=1, then go to F1.
REQ-037 With CU_STEP_EN defined, rst SHALL take priority over step.
REQ-038 Without CU_STEP_EN, there SHALL be no step port, and code 6 SHALL be illegal per REQ-030.

Verification
REQ-039 rst=1 for 2 cycles then 0 -> state_out=0 with clr_pc=1 and clr_ac=1; next cycle state_out=1 with ld_ar=1 and ar_sel=0.
REQ-040 ir_op=10 -> states 1,2,3,1; ld_pc=1 only in state 3; inc_pc=1 only in state 2.
REQ-041 ir_op=00 -> states 1,2,3,4,5,1; state 3 has ld_ar=1 and ar_sel=1; state 5 has ld_ac=1 and alu_op=00. Repeat with ir_op=01 -> alu_op=01.
REQ-042 ir_op=11 -> state 3 has inc_ac=1 and ld_ar=0; state returns to 1 after 3 cycles.
REQ-043 rst=1 pulsed during state 4 (ADD) -> next state 0; ld_ac never asserted for that instruction.
REQ-044 CU_STEP_EN defined, JMP executed, step=0 for 10 cycles -> state_out=6 with all outputs 0 throughout; step=1 -> next state 1.

Source files
------------

// File: rtl/control_unit.sv
// Moore control FSM for a small accumulator CPU: fetch, decode and execute of ADD/AND/JMP/INC.
// Define CU_STEP_EN to add a single-step HOLD state (input step) in front of every fetch.
module control_unit (
    input  logic       clk,
    input  logic       rst,
`ifdef CU_STEP_EN
    input  logic       step,
`endif
    input  logic [1:0] ir_op,
    output logic       clr_pc,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       ld_ar,
    output logic       ar_sel,
    output logic       mem_rd,
    output logic       ld_ir,
    output logic       ld_dr,
    output logic       ld_ac,
    output logic       clr_ac,
    output logic       inc_ac,
    output logic [1:0] alu_op,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_F1   = 3'd1,
        S_F2   = 3'd2,
        S_DEC  = 3'd3,
        S_EX1  = 3'd4,
        S_EX2  = 3'd5
`ifdef CU_STEP_EN
        ,
        S_HOLD = 3'd6
`endif
    } state_t;

    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_INC = 2'b11;

    // Every path that would start a new fetch goes through HOLD when stepping is enabled.
`ifdef CU_STEP_EN
    localparam state_t S_NEXT = S_HOLD;
`else
    localparam state_t S_NEXT = S_F1;
`endif

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_RST;
        clr_pc  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        ld_ar   = 1'b0;
        ar_sel  = 1'b0;
        mem_rd  = 1'b0;
        ld_ir   = 1'b0;
        ld_dr   = 1'b0;
        ld_ac   = 1'b0;
        clr_ac  = 1'b0;
        inc_ac  = 1'b0;
        alu_op  = 2'b00;
        case (state_q)
            S_RST: begin
                clr_pc  = 1'b1;
                clr_ac  = 1'b1;
                state_d = S_NEXT;
            end
            S_F1: begin
                ld_ar   = 1'b1;
                state_d = S_F2;
            end
            S_F2: begin
                mem_rd  = 1'b1;
                ld_ir   = 1'b1;
                inc_pc  = 1'b1;
                state_d = S_DEC;
            end
            S_DEC: begin
                if (ir_op == OP_JMP) begin
                    ld_pc   = 1'b1;
                    state_d = S_NEXT;
                end else if (ir_op == OP_INC) begin
                    inc_ac  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    // ADD/AND fetch their operand from the IR address field
                    ld_ar   = 1'b1;
                    ar_sel  = 1'b1;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                mem_rd  = 1'b1;
                ld_dr   = 1'b1;
                state_d = S_EX2;
            end
            S_EX2: begin
                ld_ac   = 1'b1;
                alu_op  = ir_op;
                state_d = S_NEXT;
            end
`ifdef CU_STEP_EN
            S_HOLD: begin
                state_d = step ? S_F1 : S_HOLD;
            end
`endif
            default: state_d = S_RST;
        endcase
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed vector table, step-mode sequence, and random run against a per-instruction model.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
`ifdef CU_STEP_EN
    logic       step;
`endif
    logic [1:0] ir_op;
    logic       clr_pc, ld_pc, inc_pc, ld_ar, ar_sel, mem_rd, ld_ir, ld_dr, ld_ac, clr_ac, inc_ac;
    logic [1:0] alu_op;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk(clk), .rst(rst),
`ifdef CU_STEP_EN
        .step(step),
`endif
        .ir_op(ir_op), .clr_pc(clr_pc), .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_ar(ld_ar),
        .ar_sel(ar_sel), .mem_rd(mem_rd), .ld_ir(ld_ir), .ld_dr(ld_dr), .ld_ac(ld_ac),
        .clr_ac(clr_ac), .inc_ac(inc_ac), .alu_op(alu_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Output vector: {clr_pc,ld_pc,inc_pc,ld_ar,ar_sel,mem_rd,ld_ir,ld_dr,ld_ac,clr_ac,inc_ac,alu_op[1:0]}
    localparam logic [12:0] B_CLR_PC = 13'd1 << 12;
    localparam logic [12:0] B_LD_PC  = 13'd1 << 11;
    localparam logic [12:0] B_INC_PC = 13'd1 << 10;
    localparam logic [12:0] B_LD_AR  = 13'd1 << 9;
    localparam logic [12:0] B_AR_SEL = 13'd1 << 8;
    localparam logic [12:0] B_MEM_RD = 13'd1 << 7;
    localparam logic [12:0] B_LD_IR  = 13'd1 << 6;
    localparam logic [12:0] B_LD_DR  = 13'd1 << 5;
    localparam logic [12:0] B_LD_AC  = 13'd1 << 4;
    localparam logic [12:0] B_CLR_AC = 13'd1 << 3;
    localparam logic [12:0] B_INC_AC = 13'd1 << 2;

    localparam logic [12:0] O_NONE = 13'd0;
    localparam logic [12:0] O_RST  = B_CLR_PC | B_CLR_AC;
    localparam logic [12:0] O_F1   = B_LD_AR;
    localparam logic [12:0] O_F2   = B_MEM_RD | B_LD_IR | B_INC_PC;
    localparam logic [12:0] O_DECM = B_LD_AR | B_AR_SEL;
    localparam logic [12:0] O_JMP  = B_LD_PC;
    localparam logic [12:0] O_INC  = B_INC_AC;
    localparam logic [12:0] O_EX1  = B_MEM_RD | B_LD_DR;
    localparam logic [12:0] O_EX2  = B_LD_AC;

    function automatic logic [12:0] act_outs();
        return {clr_pc, ld_pc, inc_pc, ld_ar, ar_sel, mem_rd, ld_ir, ld_dr, ld_ac, clr_ac, inc_ac, alu_op};
    endfunction

    // Model: m_pos is the cycle index inside the current instruction (0 = first fetch cycle).
    bit m_rst  = 1'b0;
    bit m_hold = 1'b0;
    int m_pos  = 0;

    task automatic model_new_instr();
`ifdef CU_STEP_EN
        m_hold = 1'b1;
`else
        m_pos = 0;
`endif
    endtask

    task automatic model_step(input logic r, input logic [1:0] op, input logic st);
        if (r) begin
            m_rst = 1'b1; m_hold = 1'b0; m_pos = 0;
        end else if (m_rst) begin
            m_rst = 1'b0; model_new_instr();
        end else if (m_hold) begin
            if (st) begin m_hold = 1'b0; m_pos = 0; end
        end else begin
            case (m_pos)
                2:       if (op[1]) model_new_instr(); else m_pos = 3;
                4:       model_new_instr();
                default: m_pos = m_pos + 1;
            endcase
        end
    endtask

    function automatic logic [12:0] model_outs(input logic [1:0] op);
        if (m_rst)  return O_RST;
        if (m_hold) return O_NONE;
        case (m_pos)
            0: return O_F1;
            1: return O_F2;
            2: return (op == 2'b10) ? O_JMP : (op == 2'b11) ? O_INC : O_DECM;
            3: return O_EX1;
            default: return O_EX2 | {11'd0, op};
        endcase
    endfunction

    function automatic logic [2:0] model_state();
        if (m_rst)  return 3'd0;
        if (m_hold) return 3'd6;
        return 3'(m_pos + 1);
    endfunction

    task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] op, input logic st);
        @(negedge clk);
        rst   = r;
        ir_op = op;
`ifdef CU_STEP_EN
        step  = st;
`endif
        #1;
    endtask

    // One cycle against explicit expectations; the model tracks along so the random phase starts in sync.
    task automatic run(input logic r, input logic [1:0] op, input logic st,
                       input logic [2:0] es, input logic [12:0] eo, input string name);
        drive(r, op, st);
        chk({name, ".state"}, {10'd0, state_out}, {10'd0, es});
        chk({name, ".outs"}, act_outs(), eo);
        model_step(r, op, st);
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  op;
        logic [2:0]  es;
        logic [12:0] eo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst = 1'b1; ir_op = 2'b00;
`ifdef CU_STEP_EN
        step = 1'b0;
`endif

`ifndef CU_STEP_EN
        tbl = '{
            '{1'b1, 2'b10, 3'd0, O_RST},  '{1'b1, 2'b01, 3'd0, O_RST},
            '{1'b0, 2'b10, 3'd0, O_RST},
            '{1'b0, 2'b10, 3'd1, O_F1},   '{1'b0, 2'b10, 3'd2, O_F2},   '{1'b0, 2'b10, 3'd3, O_JMP},
            '{1'b0, 2'b00, 3'd1, O_F1},   '{1'b0, 2'b00, 3'd2, O_F2},   '{1'b0, 2'b00, 3'd3, O_DECM},
            '{1'b0, 2'b00, 3'd4, O_EX1},  '{1'b0, 2'b00, 3'd5, O_EX2},
            '{1'b0, 2'b01, 3'd1, O_F1},   '{1'b0, 2'b01, 3'd2, O_F2},   '{1'b0, 2'b01, 3'd3, O_DECM},
            '{1'b0, 2'b01, 3'd4, O_EX1},  '{1'b0, 2'b01, 3'd5, O_EX2 | 13'd1},
            '{1'b0, 2'b11, 3'd1, O_F1},   '{1'b0, 2'b11, 3'd2, O_F2},   '{1'b0, 2'b11, 3'd3, O_INC},
            '{1'b0, 2'b00, 3'd1, O_F1},   '{1'b0, 2'b00, 3'd2, O_F2},   '{1'b0, 2'b00, 3'd3, O_DECM},
            '{1'b1, 2'b00, 3'd4, O_EX1},  '{1'b0, 2'b00, 3'd0, O_RST},  '{1'b0, 2'b01, 3'd1, O_F1},
            '{1'b1, 2'b01, 3'd2, O_F2},   '{1'b0, 2'b00, 3'd0, O_RST},
            '{1'b0, 2'b01, 3'd1, O_F1},   '{1'b0, 2'b01, 3'd2, O_F2},   '{1'b0, 2'b01, 3'd3, O_DECM},
            '{1'b0, 2'b00, 3'd4, O_EX1},  '{1'b0, 2'b11, 3'd5, O_EX2 | 13'd3},
            '{1'b0, 2'b10, 3'd1, O_F1}
        };
        foreach (tbl[i]) run(tbl[i].r, tbl[i].op, 1'b0, tbl[i].es, tbl[i].eo, $sformatf("vec%0d", i));
`else
        run(1'b1, 2'b10, 1'b0, 3'd0, O_RST, "st_rst");
        run(1'b0, 2'b10, 1'b0, 3'd0, O_RST, "st_rst_rel");
        run(1'b0, 2'b10, 1'b1, 3'd6, O_NONE, "st_hold0");
        run(1'b0, 2'b10, 1'b0, 3'd1, O_F1, "st_f1");
        run(1'b0, 2'b10, 1'b0, 3'd2, O_F2, "st_f2");
        run(1'b0, 2'b10, 1'b0, 3'd3, O_JMP, "st_jmp");
        for (int i = 0; i < 10; i++) run(1'b0, 2'($urandom), 1'b0, 3'd6, O_NONE, $sformatf("st_wait%0d", i));
        run(1'b0, 2'b00, 1'b1, 3'd6, O_NONE, "st_go");
        run(1'b0, 2'b00, 1'b0, 3'd1, O_F1, "st_after_go");
        run(1'b0, 2'b00, 1'b0, 3'd2, O_F2, "st_f2b");
        run(1'b0, 2'b11, 1'b0, 3'd3, O_INC, "st_inc");
        run(1'b1, 2'b00, 1'b1, 3'd6, O_NONE, "st_rst_prio");
        run(1'b0, 2'b00, 1'b1, 3'd0, O_RST, "st_rst_won");
`endif

        // Random phase: rst ~1/32, step ~1/4, opcode changes every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [1:0] op;
            logic       st;
            r  = ($urandom_range(0, 31) == 0);
            op = 2'($urandom);
            st = ($urandom_range(0, 3) == 0);
            drive(r, op, st);
            chk("rnd.state", {10'd0, state_out}, {10'd0, model_state()});
            chk("rnd.outs", act_outs(), model_outs(op));
            chk("rnd.pc_excl", {12'd0, ld_pc & inc_pc}, 13'd0);
            model_step(r, op, st);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
